dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the memory-side end of the CPU's MEM-stage load/store interface.
- Accepts one word request at a time from the pipeline's EX/MEM outputs and holds the pipeline via stall_o while a configurable wait-state latency elapses.
- Completes the access against an internal word array, returns read data with a one-cycle ack_o, and flags misaligned or out-of-range addresses.
- Replaces the zero-latency combinational data memory so the pipeline can be exercised against realistic memory timing.

---
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: holds the pipeline for
// LATENCY cycles, then completes the access with a one-cycle ack and error flag.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned LATENCY    = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] RELOAD = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              count;
    logic                    cap_we;
    logic [DEPTH_LOG2-1:0]   cap_idx;
    logic [31:0]             cap_wdata;
    logic [31:0]             mem [DEPTH];

    logic                    bad_in;
    logic                    go_resp;
    logic                    acc_we;
    logic                    acc_bad;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [31:0]             acc_wdata;

    assign bad_in  = (addr_i[1:0] != 2'b00) || (addr_i[31:DEPTH_LOG2+2] != '0);
    assign stall_o = ((state == ST_IDLE) && req_i) || (state == ST_WAIT);

    // The access completing on this edge comes straight from the inputs when
    // IDLE skips WAIT, otherwise from the registers captured on acceptance.
    always_comb begin
        go_resp   = 1'b0;
        acc_we    = cap_we;
        acc_bad   = 1'b0;
        acc_idx   = cap_idx;
        acc_wdata = cap_wdata;
        case (state)
            ST_IDLE: begin
                acc_we    = we_i;
                acc_bad   = bad_in;
                acc_idx   = addr_i[DEPTH_LOG2+1:2];
                acc_wdata = wdata_i;
                go_resp   = req_i && ((LATENCY == 1) || bad_in);
            end
            ST_WAIT: go_resp = (count == 4'd0);
            default: go_resp = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            count     <= '0;
            cap_we    <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            rdata_o   <= '0;
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        cap_we    <= we_i;
                        cap_idx   <= addr_i[DEPTH_LOG2+1:2];
                        cap_wdata <= wdata_i;
                        if (go_resp) begin
                            state <= ST_RESP;
                        end else begin
                            count <= RELOAD;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (go_resp) begin
                        state <= ST_RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (go_resp) begin
                ack_o <= 1'b1;
                if (acc_bad) begin
                    err_o   <= 1'b1;
                    rdata_o <= '0;
                end else if (acc_we) begin
                    mem[acc_idx] <= acc_wdata;
                end else begin
                    rdata_o <= mem[acc_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=3, one at LATENCY=1,
// sharing the request bus with req steered by sel.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        sel = 1'b0;

    logic        req3, ack3, err3, stall3;
    logic        req1, ack1, err1, stall1;
    logic [31:0] rdata3, rdata1;
    logic        cur_ack, cur_err, cur_stall;
    logic [31:0] cur_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign req3      = req && !sel;
    assign req1      = req && sel;
    assign cur_ack   = sel ? ack1 : ack3;
    assign cur_err   = sel ? err1 : err3;
    assign cur_stall = sel ? stall1 : stall3;
    assign cur_rdata = sel ? rdata1 : rdata3;

    dmem_responder #(.DEPTH_LOG2(5), .LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata3), .ack_o(ack3), .err_o(err3), .stall_o(stall3)
    );

    dmem_responder #(.DEPTH_LOG2(5), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata1), .ack_o(ack1), .err_o(err1), .stall_o(stall1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that ends the ack cycle.
    task automatic access(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int exp_stall, input logic exp_err,
                          input logic chk_rd, input logic [31:0] exp_rdata);
        int  stalls = 0;
        bit  got = 1'b0;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (cur_ack) begin
                got = 1'b1;
                check({tag, "_stall_at_ack"}, 32'(cur_stall), 32'd0);
                check({tag, "_err"}, 32'(cur_err), 32'(exp_err));
                if (chk_rd) check({tag, "_rdata"}, cur_rdata, exp_rdata);
            end else if (cur_stall) begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
        check({tag, "_acked"}, 32'(got), 32'd1);
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stall));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdata", rdata3, 32'h0);
        check("rst_ack", 32'(ack3), 32'd0);
        check("rst_err", 32'(err3), 32'd0);
        check("rst_stall", 32'(stall3), 32'd0);
        check("rst_stall_l1", 32'(stall1), 32'd0);
        @(posedge clk); #1;

        sel = 1'b0;
        access("ld0", 1'b0, 32'h0, 32'h0, 3, 1'b0, 1'b1, 32'h0);
        access("st14", 1'b1, 32'h14, 32'hDEADBEEF, 3, 1'b0, 1'b1, 32'h0);
        access("ld14", 1'b0, 32'h14, 32'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF);
        access("ld16_mis", 1'b0, 32'h16, 32'h0, 1, 1'b1, 1'b1, 32'h0);
        access("ld14_again", 1'b0, 32'h14, 32'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF);
        idle(2);
        @(negedge clk);
        check("rdata_hold", rdata3, 32'hDEADBEEF);
        check("ack_idle", 32'(ack3), 32'd0);
        @(posedge clk); #1;
        access("st80_oor", 1'b1, 32'h80, 32'hCAFEF00D, 1, 1'b1, 1'b1, 32'h0);
        access("ld00_after_oor", 1'b0, 32'h0, 32'h0, 3, 1'b0, 1'b1, 32'h0);
        access("ld7c", 1'b0, 32'h7C, 32'h0, 3, 1'b0, 1'b1, 32'h0);
        access("ld_hi_oor", 1'b0, 32'h8000_0004, 32'h0, 1, 1'b1, 1'b1, 32'h0);
        access("ld14_prep", 1'b0, 32'h14, 32'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF);

        // Reset lands while the store sits in WAIT.
        req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h12345678;
        @(posedge clk); #1;
        check("mid_wait_stall", 32'(stall3), 32'd1);
        rst = 1'b1; req = 1'b0;
        #1;
        check("mid_rst_rdata", rdata3, 32'h0);
        check("mid_rst_ack", 32'(ack3), 32'd0);
        check("mid_rst_err", 32'(err3), 32'd0);
        check("mid_rst_stall", 32'(stall3), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access("ld8_after_rst", 1'b0, 32'h8, 32'h0, 3, 1'b0, 1'b1, 32'h0);
        access("ld14_after_rst", 1'b0, 32'h14, 32'h0, 3, 1'b0, 1'b1, 32'h0);

        sel = 1'b1;
        access("l1_st0", 1'b1, 32'h0, 32'h1, 1, 1'b0, 1'b0, 32'h0);
        access("l1_st4", 1'b1, 32'h4, 32'h2, 1, 1'b0, 1'b0, 32'h0);
        access("l1_st8", 1'b1, 32'h8, 32'h3, 1, 1'b0, 1'b0, 32'h0);
        access("l1_ld0", 1'b0, 32'h0, 32'h0, 1, 1'b0, 1'b1, 32'h1);
        access("l1_ld4", 1'b0, 32'h4, 32'h0, 1, 1'b0, 1'b1, 32'h2);
        access("l1_ld8", 1'b0, 32'h8, 32'h0, 1, 1'b0, 1'b1, 32'h3);
        access("l1_mis", 1'b0, 32'h9, 32'h0, 1, 1'b1, 1'b1, 32'h0);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
